mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1, 3-bit-wide datapath mux among four requesters (e.g. register-file read ports or ALU source operands in the 6-bit CPU).
- Owns the mux's 2-bit select line and issues a one-hot grant.
- Grant is held until the owner releases it. Handoff to the next requester has no idle bubble.
- Sits between requesting units and the mux select input.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i requests mux input i.
- gnt  output  4  one-hot grant, or all-zero when idle. Registered.
- sel  output  2  mux select, equal to the index of the granted requester. Registered.
- busy  output  1  high while any grant is active. Registered.
- grant_pulse  output  1  one-cycle pulse on the first cycle of every new grant, including handoffs.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, including mid-grant):
  - gnt=0000, sel=00, busy=0, grant_pulse=0.
  - Last-owner pointer last=3, so requester 0 has highest priority after reset.
  - State=IDLE, hold counter=0.
- State IDLE:
  - gnt=0, busy=0. sel keeps its last value and does not glitch to 0.
  - If req!=0 at a rising edge: pick the first set bit scanning (last+1), (last+2), ... mod 4.
  - Next state GRANT: gnt=onehot(pick), sel=pick, busy=1, grant_pulse=1, last=pick.
  - Latency: a request sampled at edge N is visible as a grant after edge N (one cycle).
- State GRANT (owner o=sel):
  - Case req[o]=1: stay. Outputs are unchanged and grant_pulse=0.
  - Case req[o]=0 and another req bit set: hand off at the same edge. The new owner is the first set bit scanning from (o+1) mod 4. grant_pulse=1, last=new owner, no idle cycle.
  - Case req[o]=0 and no other req: go to IDLE. gnt=0, busy=0, sel held.
- Simultaneous requests are resolved strictly by rotating priority. No requester waits more than 3 grants.
- Requests that rise and fall between sampling edges are ignored.
- gnt is always one-hot or zero; sel==index(gnt) whenever busy=1.
- Non-owner req changes during GRANT have no effect until release.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The hold counter increments each cycle in GRANT and resets on every new grant.
  - When the counter reaches MAX_HOLD-1 while req[o]=1 and another request is pending, the grant is forcibly handed off at that edge by the normal rotation. grant_pulse=1.
  - If no other request is pending, the owner keeps the grant and the counter restarts at 0. grant_pulse stays 0.
- When undefined:
  - No counter logic is present.
  - The owner holds the grant indefinitely while req[o]=1.

Decomposition:
- Shared package arb_pkg holds:
  - REQ_N=4 and SEL_W=2.
  - State encoding (IDLE=1'b0, GRANT=1'b1).
  - A onehot-from-index helper constant or function.
- One combinational sub-module, rr_pick: inputs req[3:0] and start[1:0]; outputs valid and idx[1:0]. It returns the first set bit at or after start, mod 4.
- The arbiter instantiates rr_pick once, with start=(last+1) mod 4. It uses it for both idle pick and handoff; on handoff the owner's bit is masked out.

Test Plan:
- Reset: hold rst_n=0 → gnt=0000, sel=00, busy=0. Release rst_n and drive req=0100 → after 1 edge gnt=0100, sel=10, busy=1, grant_pulse=1 for one cycle.
- Fairness: req=1111 constant, owner drops its req for one cycle after each grant → grant order 0,1,2,3,0. Each handoff has no idle cycle and each raises grant_pulse.
- Release to idle: owner 1 only, req 0010→0000 → next edge gnt=0000, busy=0, sel stays 01. New req 1000 → gnt=1000, sel=11.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held constant → gnt alternates 0001 for 4 cycles, then 0010 for 4 cycles. With req=0001 only, owner 0 is held forever with grant_pulse=0.
- No timeout (macro undefined): req=0011 held for 50 cycles → gnt=0001 throughout.
- Async reset mid-grant: gnt=0100, pull rst_n low between edges → gnt=0000, busy=0 immediately, before the next edge. After release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the mux-select arbiter: requester count, select width,
// state encoding and a one-hot helper.
package arb_pkg;

  localparam int unsigned REQ_N = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  function automatic logic [REQ_N-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request bit at or after start, mod 4.
module rr_pick
  import arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = start;
    cand  = '0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      cand = start + SEL_W'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of a 4:1 datapath mux select with hold-until-release grants.
// Optional forced rotation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       grant_pulse
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || CNT_W > 31 ||
      (CNT_W < 32 && (32'd1 << CNT_W) <= MAX_HOLD)) begin : g_bad_cfg
    $error("mux_sel_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  logic [0:0]       state;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] start;
  logic [REQ_N-1:0] pick_req;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             own_req;
  logic             take;
  logic             drop;

  assign start   = last + 1'b1;
  assign own_req = req[sel];
  // In GRANT last==sel, so masking the owner makes the scan start at owner+1.
  assign pick_req = (state == GRANT) ? (req & ~onehot(sel)) : req;

  rr_pick u_pick (
    .req   (pick_req),
    .start (start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state != GRANT || take || drop || expired)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    if (state == IDLE) begin
      take = pick_valid;
    end else if (!own_req) begin
      take = pick_valid;
      drop = !pick_valid;
    end else begin
      take = expired && pick_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= '1;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      grant_pulse <= 1'b0;
    end else begin
      grant_pulse <= take;
      if (take) begin
        state <= GRANT;
        last  <= pick_idx;
        gnt   <= onehot(pick_idx);
        sel   <= pick_idx;
        busy  <= 1'b1;
      end else if (drop) begin
        state <= IDLE;
        gnt   <= '0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter; timeout expectations follow ARB_TIMEOUT_EN.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       grant_pulse;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .sel         (sel),
    .busy        (busy),
    .grant_pulse (grant_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic p);
    chk({tag, "_gnt"},   {4'h0, gnt},          {4'h0, g});
    chk({tag, "_sel"},   {6'h0, sel},          {6'h0, s});
    chk({tag, "_busy"},  {7'h0, busy},         {7'h0, b});
    chk({tag, "_pulse"}, {7'h0, grant_pulse},  {7'h0, p});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       exp_p;

    req   = 4'b0000;
    rst_n = 1'b0;
    repeat (2) step();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    req   = 4'b0100;
    step();
    chk_all("first_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
    step();
    chk_all("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // async reset between edges while requester 2 owns the mux
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    req   = 4'b0110;
    rst_n = 1'b1;
    step();
    chk_all("post_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b1);

    req = 4'b0010;
    step();
    chk_all("own1_stay", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_all("release_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    chk_all("idle_sel_held", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b1000;
    step();
    chk_all("grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b0000;
    step();
    chk_all("idle3", 4'b0000, 2'd3, 1'b0, 1'b0);

    // fairness: all request, owner drops for one edge after each grant
    req = 4'b1111;
    step();
    chk_all("rr0", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = 4'b1110;
    step();
    chk_all("rr1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1101;
    step();
    chk_all("rr2", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b1011;
    step();
    chk_all("rr3", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b0111;
    step();
    chk_all("rr0_again", 4'b0001, 2'd0, 1'b1, 1'b1);

    req = 4'b1111;
    step();
    chk_all("stay_all", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0011;
    step();
    chk_all("nonowner_change", 4'b0001, 2'd0, 1'b1, 1'b0);

    req = 4'b1010;
    step();
    chk_all("skip_to1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1001;
    step();
    chk_all("skip_to3", 4'b1000, 2'd3, 1'b1, 1'b1);
    req = 4'b0110;
    step();
    chk_all("wrap_to1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b0000;
    step();
    chk_all("idle1", 4'b0000, 2'd1, 1'b0, 1'b0);

    // last=1: scan 2,3,0 finds requester 0 first
    req = 4'b0011;
    for (int i = 0; i < 50; i++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      exp_g = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      exp_p = ((i % 4) == 0);
`else
      exp_g = 4'b0001;
      exp_p = (i == 0);
`endif
      chk_all($sformatf("hold_c%0d", i), exp_g, (exp_g == 4'b0001) ? 2'd0 : 2'd1, 1'b1, exp_p);
    end

    req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_all($sformatf("solo_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end

    req = 4'b0000;
    step();
    chk_all("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
